gtp_rxframer: RTL and testbench

GTP_RXFRAMER -- requirements
Module: gtp_rxframer

---
 rtl/gtp_rxframer.sv | 177 +++++++++++++++++
 tb/tb_gtp_rxframer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_rxframer.sv
// gtp_rxframer: receive-side block framer for a GTP lane.
// Acquires comma lock, then parses SOF / header / payload / checksum blocks
// and forwards header and payload words to the receive FIFO one cycle later.
//
// state | meaning
// ------+-------------------------------------------------------------
// LOST  | no lock; counting consecutive clean idle commas
// IDLE  | locked; waiting for SOF between blocks
// HDR   | SOF seen; next word must be a header with bit15 set
// DATA  | forwarding payload words, remaining count in rem_cnt
// CSUM  | expecting the checksum word (never forwarded)
module gtp_rxframer #(
    parameter int          LOCKCNT  = 4,
    parameter logic [15:0] CH_COMMA = 16'h00BC,
    parameter logic [15:0] CH_SOF   = 16'h00FB
) (
    input  logic        gtp_clk,
    input  logic        rreset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_isk,
    input  logic        rx_err,
    output logic [15:0] gtp_dat,
    output logic        gtp_vld,
    output logic        link_up,
    output logic        frm_err,
    output logic [15:0] blk_cnt,
    output logic [15:0] err_cnt
);

    localparam int          LW      = (LOCKCNT < 2) ? 1 : $clog2(LOCKCNT + 1);
    localparam logic [LW-1:0] LOCK_LD = LW'(LOCKCNT);

    typedef enum logic [2:0] {
        ST_LOST = 3'd0,
        ST_IDLE = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lock_rem;
    logic [11:0]   rem_cnt;
    logic [15:0]   csum;
    logic [15:0]   blk_cnt_q;
    logic [15:0]   err_cnt_q;

    logic is_idle, is_sof, is_data, hdr_ok;
    logic fwd, ferr, blk_inc;

    assign is_idle = (rx_data == CH_COMMA) && (rx_isk == 2'b01) && !rx_err;
    assign is_sof  = (rx_data == CH_SOF)   && (rx_isk == 2'b01) && !rx_err;
    assign is_data = (rx_isk == 2'b00) && !rx_err;
    assign hdr_ok  = is_data && rx_data[15];

    assign blk_cnt = blk_cnt_q;
    assign err_cnt = err_cnt_q;

    // State register
    always_ff @(posedge gtp_clk) begin
        if (rreset) state <= ST_LOST;
        else        state <= state_nxt;
    end

    // Next-state decode; a coding error always drops the lane back to LOST
    always_comb begin
        state_nxt = state;
        if (rx_err) begin
            state_nxt = ST_LOST;
        end else begin
            case (state)
                ST_LOST: if (is_idle && lock_rem == LW'(1)) state_nxt = ST_IDLE;
                ST_IDLE: if (is_sof) state_nxt = ST_HDR;
                ST_HDR: begin
                    if (hdr_ok) state_nxt = (rx_data[11:0] == 12'd0) ? ST_CSUM : ST_DATA;
                    else        state_nxt = ST_IDLE;
                end
                ST_DATA: begin
                    if (!is_data)                state_nxt = ST_IDLE;
                    else if (rem_cnt == 12'd1)   state_nxt = ST_CSUM;
                end
                ST_CSUM: state_nxt = ST_IDLE;
                default: state_nxt = ST_LOST;
            endcase
        end
    end

    // Per-word actions: forward, flag a framing error, or credit a good block
    always_comb begin
        fwd     = 1'b0;
        ferr    = 1'b0;
        blk_inc = 1'b0;
        if (rx_err) begin
            ferr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: ferr = !is_idle && !is_sof;
                ST_HDR: begin
                    if (hdr_ok) fwd  = 1'b1;
                    else        ferr = 1'b1;
                end
                ST_DATA: begin
                    if (is_data) fwd  = 1'b1;
                    else         ferr = 1'b1;
                end
                ST_CSUM: begin
                    if (is_data && rx_data == csum) blk_inc = 1'b1;
                    else                            ferr    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Lock down-counter and link status; reloads on any break in the idle run
    always_ff @(posedge gtp_clk) begin
        if (rreset) begin
            lock_rem <= LOCK_LD;
            link_up  <= 1'b0;
        end else if (rx_err) begin
            lock_rem <= LOCK_LD;
            link_up  <= 1'b0;
        end else if (state == ST_LOST) begin
            if (is_idle) begin
                if (lock_rem == LW'(1)) begin
                    lock_rem <= LOCK_LD;
                    link_up  <= 1'b1;
                end else begin
                    lock_rem <= lock_rem - LW'(1);
                end
            end else begin
                lock_rem <= LOCK_LD;
            end
        end else begin
            lock_rem <= LOCK_LD;
        end
    end

    // Payload remaining count and running checksum
    always_ff @(posedge gtp_clk) begin
        if (rreset) begin
            rem_cnt <= 12'd0;
            csum    <= 16'd0;
        end else if (!rx_err && state == ST_HDR && hdr_ok) begin
            rem_cnt <= rx_data[11:0];
            csum    <= rx_data;
        end else if (!rx_err && state == ST_DATA && is_data) begin
            rem_cnt <= rem_cnt - 12'd1;
            csum    <= csum ^ rx_data;
        end
    end

    // Registered FIFO-side outputs; idle cycles carry a comma for half-word flush
    always_ff @(posedge gtp_clk) begin
        if (rreset) begin
            gtp_dat <= CH_COMMA;
            gtp_vld <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            gtp_dat <= fwd ? rx_data : CH_COMMA;
            gtp_vld <= fwd;
            frm_err <= ferr;
        end
    end

    // Saturating block and error counters
    always_ff @(posedge gtp_clk) begin
        if (rreset) begin
            blk_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (blk_inc && blk_cnt_q != 16'hFFFF) blk_cnt_q <= blk_cnt_q + 16'd1;
            if (ferr && err_cnt_q != 16'hFFFF)    err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_gtp_rxframer.sv
// tb_gtp_rxframer: word streams (directed and random) are parsed by a
// block-level reference model that predicts every output cycle by cycle.
module tb_gtp_rxframer;

    localparam int          LOCKCNT  = 4;
    localparam logic [15:0] CH_COMMA = 16'h00BC;
    localparam logic [15:0] CH_SOF   = 16'h00FB;
    localparam int          NOF      = 1 << 30;
    localparam int          MAXW     = 4096;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        e;
    } wd_t;

    logic        gtp_clk = 1'b0;
    logic        rreset  = 1'b1;
    logic [15:0] rx_data = 16'h0000;
    logic [1:0]  rx_isk  = 2'b00;
    logic        rx_err  = 1'b0;
    logic [15:0] gtp_dat;
    logic        gtp_vld;
    logic        link_up;
    logic        frm_err;
    logic [15:0] blk_cnt;
    logic [15:0] err_cnt;

    gtp_rxframer #(.LOCKCNT(LOCKCNT), .CH_COMMA(CH_COMMA), .CH_SOF(CH_SOF)) dut (
        .gtp_clk (gtp_clk),
        .rreset  (rreset),
        .rx_data (rx_data),
        .rx_isk  (rx_isk),
        .rx_err  (rx_err),
        .gtp_dat (gtp_dat),
        .gtp_vld (gtp_vld),
        .link_up (link_up),
        .frm_err (frm_err),
        .blk_cnt (blk_cnt),
        .err_cnt (err_cnt)
    );

    always #5 gtp_clk = ~gtp_clk;

    int n_chk  = 0;
    int n_fail = 0;

    wd_t         q[$];
    logic        e_vld[MAXW];
    logic [15:0] e_dat[MAXW];
    logic        e_fe [MAXW];
    logic        e_lk [MAXW];
    logic [15:0] e_blk[MAXW];
    logic [15:0] e_err[MAXW];
    logic [15:0] m_blk, m_err;
    bit          forced;
    int          force_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit w_idle(input wd_t w);
        return (w.d == CH_COMMA) && (w.k == 2'b01) && !w.e;
    endfunction

    function automatic bit w_sof(input wd_t w);
        return (w.d == CH_SOF) && (w.k == 2'b01) && !w.e;
    endfunction

    // ---------------- reference model ----------------
    task automatic m_apply(input int i);
        if (i >= force_at && !forced) begin
            forced = 1'b1;
            m_err  = 16'hFFFE;
        end
    endtask

    task automatic m_flag(input int i);
        m_apply(i);
        e_fe[i] = 1'b1;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endtask

    task automatic m_put(input int i, input bit lk);
        m_apply(i);
        e_lk[i]  = lk;
        e_blk[i] = m_blk;
        e_err[i] = m_err;
    endtask

    task automatic m_fwd(input int i);
        e_vld[i] = 1'b1;
        e_dat[i] = q[i].d;
    endtask

    // Recursive-descent parse of the whole stream: acquire lock, then blocks.
    task automatic model_run();
        int          n;
        int          i;
        int          run;
        int          len;
        int          k;
        bit          locked;
        bit          brk;
        logic [15:0] sum;
        n = q.size();
        i = 0;
        for (int j = 0; j < n; j++) begin
            e_vld[j] = 1'b0;
            e_dat[j] = CH_COMMA;
            e_fe[j]  = 1'b0;
        end
        while (i < n) begin
            run    = 0;
            locked = 1'b0;
            while (i < n && !locked) begin
                if (q[i].e) begin
                    m_flag(i);
                    run = 0;
                end else if (w_idle(q[i])) begin
                    run++;
                end else begin
                    run = 0;
                end
                if (run == LOCKCNT) locked = 1'b1;
                m_put(i, locked);
                i++;
            end
            while (i < n && locked) begin
                if (q[i].e) begin
                    m_flag(i); locked = 1'b0; m_put(i, 1'b0); i++;
                end else if (w_idle(q[i])) begin
                    m_put(i, 1'b1); i++;
                end else if (!w_sof(q[i])) begin
                    m_flag(i); m_put(i, 1'b1); i++;
                end else begin
                    m_put(i, 1'b1); i++;
                    if (i >= n) break;
                    if (q[i].e) begin
                        m_flag(i); locked = 1'b0; m_put(i, 1'b0); i++;
                        continue;
                    end
                    if (q[i].k != 2'b00 || !q[i].d[15]) begin
                        m_flag(i); m_put(i, 1'b1); i++;
                        continue;
                    end
                    m_fwd(i);
                    sum = q[i].d;
                    len = int'(q[i].d[11:0]);
                    m_put(i, 1'b1); i++;
                    brk = 1'b0;
                    for (k = 0; k < len && i < n && !brk; k++) begin
                        if (q[i].e) begin
                            m_flag(i); locked = 1'b0; brk = 1'b1;
                        end else if (q[i].k != 2'b00) begin
                            m_flag(i); brk = 1'b1;
                        end else begin
                            m_fwd(i); sum = sum ^ q[i].d;
                        end
                        m_put(i, locked); i++;
                    end
                    if (brk || i >= n) continue;
                    if (q[i].e) begin
                        m_flag(i); locked = 1'b0;
                    end else if (q[i].k == 2'b00 && q[i].d == sum) begin
                        if (m_blk != 16'hFFFF) m_blk = m_blk + 16'd1;
                    end else begin
                        m_flag(i);
                    end
                    m_put(i, locked); i++;
                end
            end
        end
    endtask

    // ---------------- stimulus builders ----------------
    task automatic push_w(input logic [15:0] d, input logic [1:0] k, input logic e);
        wd_t w;
        w.d = d; w.k = k; w.e = e;
        q.push_back(w);
    endtask

    task automatic push_idle(input int n);
        for (int j = 0; j < n; j++) push_w(CH_COMMA, 2'b01, 1'b0);
    endtask

    // cut < len truncates the payload with a comma K-character
    task automatic push_block(input int len, input bit bad, input int cut);
        logic [15:0] h, s, w;
        h = {1'b1, 3'($urandom), 12'(len)};
        s = h;
        push_w(CH_SOF, 2'b01, 1'b0);
        push_w(h, 2'b00, 1'b0);
        for (int j = 0; j < len; j++) begin
            if (j == cut) begin
                push_w(CH_COMMA, 2'b01, 1'b0);
                return;
            end
            w = 16'($urandom);
            s = s ^ w;
            push_w(w, 2'b00, 1'b0);
        end
        push_w(bad ? (s ^ (16'd1 << $urandom_range(0, 15))) : s, 2'b00, 1'b0);
    endtask

    task automatic gen_random(input int items);
        int r, len;
        for (int j = 0; j < items; j++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: push_idle($urandom_range(1, 6));
                3, 4:    push_block($urandom_range(0, 5), 1'b0, NOF);
                5:       push_block($urandom_range(0, 5), 1'b1, NOF);
                6: begin
                    len = $urandom_range(2, 6);
                    push_block(len, 1'b0, $urandom_range(0, len - 1));
                end
                7:       push_w(16'($urandom), 2'($urandom), 1'b1);
                8:       push_w(16'($urandom), 2'b00, 1'b0);
                default: begin
                    push_w(CH_SOF, 2'b01, 1'b0);
                    push_w({1'b0, 15'($urandom)}, 2'b00, 1'b0);
                end
            endcase
        end
    endtask

    // ---------------- drive and compare ----------------
    task automatic do_reset();
        @(negedge gtp_clk);
        rreset  = 1'b1;
        rx_data = 16'($urandom);
        rx_isk  = 2'($urandom);
        rx_err  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge gtp_clk); #1;
            chk("rst_vld",  gtp_vld, 0);
            chk("rst_dat",  gtp_dat, CH_COMMA);
            chk("rst_link", link_up, 0);
            chk("rst_ferr", frm_err, 0);
            chk("rst_blk",  blk_cnt, 0);
            chk("rst_err",  err_cnt, 0);
        end
    endtask

    task automatic run_stream(input int fidx);
        int n;
        n        = q.size();
        force_at = fidx;
        forced   = 1'b0;
        m_blk    = 16'd0;
        m_err    = 16'd0;
        model_run();
        for (int i = 0; i < n; i++) begin
            @(negedge gtp_clk);
            if (i == fidx) begin
                force dut.err_cnt_q = 16'hFFFE;
                #1;
                release dut.err_cnt_q;
            end
            rreset  = 1'b0;
            rx_data = q[i].d;
            rx_isk  = q[i].k;
            rx_err  = q[i].e;
            @(posedge gtp_clk); #1;
            chk($sformatf("vld[%0d]", i),  gtp_vld, e_vld[i]);
            chk($sformatf("dat[%0d]", i),  gtp_dat, e_dat[i]);
            chk($sformatf("ferr[%0d]", i), frm_err, e_fe[i]);
            chk($sformatf("link[%0d]", i), link_up, e_lk[i]);
            chk($sformatf("blk[%0d]", i),  blk_cnt, e_blk[i]);
            chk($sformatf("err[%0d]", i),  err_cnt, e_err[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // lock after exactly LOCKCNT idles
        do_reset(); q.delete();
        push_idle(4);
        run_stream(NOF);
        chk("lock4", link_up, 1);

        // broken idle run never locks
        do_reset(); q.delete();
        push_idle(3); push_w(16'h0001, 2'b00, 1'b0); push_idle(3);
        run_stream(NOF);
        chk("nolock", link_up, 0);

        // good L=3 block
        do_reset(); q.delete();
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8003, 2'b00, 1'b0);
        push_w(16'h0001, 2'b00, 1'b0); push_w(16'h0002, 2'b00, 1'b0);
        push_w(16'h0003, 2'b00, 1'b0); push_w(16'h8003, 2'b00, 1'b0);
        run_stream(NOF);
        chk("good_blk", blk_cnt, 1);
        chk("good_err", err_cnt, 0);

        // same block, bad checksum
        do_reset(); q.delete();
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8003, 2'b00, 1'b0);
        push_w(16'h0001, 2'b00, 1'b0); push_w(16'h0002, 2'b00, 1'b0);
        push_w(16'h0003, 2'b00, 1'b0); push_w(16'h0000, 2'b00, 1'b0);
        run_stream(NOF);
        chk("badc_blk", blk_cnt, 0);
        chk("badc_err", err_cnt, 1);

        // empty block
        do_reset(); q.delete();
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8000, 2'b00, 1'b0);
        push_w(16'h8000, 2'b00, 1'b0);
        run_stream(NOF);
        chk("empty_blk", blk_cnt, 1);

        // rx_err mid-payload drops lock; next block ignored until relock
        do_reset(); q.delete();
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8005, 2'b00, 1'b0);
        push_w(16'h0001, 2'b00, 1'b0); push_w(16'h0002, 2'b00, 1'b0);
        push_w(16'h1234, 2'b00, 1'b1);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8001, 2'b00, 1'b0);
        push_w(16'h0007, 2'b00, 1'b0); push_w(16'h8006, 2'b00, 1'b0);
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8001, 2'b00, 1'b0);
        push_w(16'h0009, 2'b00, 1'b0); push_w(16'h8008, 2'b00, 1'b0);
        run_stream(NOF);
        chk("rxerr_err",  err_cnt, 1);
        chk("rxerr_blk",  blk_cnt, 1);
        chk("rxerr_link", link_up, 1);

        // err_cnt saturation from a forced preload
        do_reset(); q.delete();
        push_idle(4);
        for (int j = 0; j < 4; j++) push_w(16'h1111, 2'b00, 1'b0);
        run_stream(4);
        chk("sat_err", err_cnt, 16'hFFFF);

        // reset mid-block aborts it; tail words after reset are not forwarded
        do_reset(); q.delete();
        push_idle(4);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8004, 2'b00, 1'b0);
        push_w(16'h0001, 2'b00, 1'b0); push_w(16'h0002, 2'b00, 1'b0);
        run_stream(NOF);
        do_reset(); q.delete();
        push_w(16'h0003, 2'b00, 1'b0); push_w(16'h0004, 2'b00, 1'b0);
        push_w(16'h8004, 2'b00, 1'b0);
        push_w(CH_SOF, 2'b01, 1'b0); push_w(16'h8000, 2'b00, 1'b0);
        push_w(16'h8000, 2'b00, 1'b0);
        run_stream(NOF);
        chk("abort_blk", blk_cnt, 0);
        chk("abort_err", err_cnt, 0);

        // randomized streams
        for (int s = 0; s < 6; s++) begin
            do_reset(); q.delete();
            push_idle(LOCKCNT);
            gen_random(50);
            run_stream(NOF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
